// File: rtl/pipelined_alu_stream_if.sv
// Stream bundle for the pipelined ALU: operand/function input beat and result/flag output beat.
// master drives the input beat and out_ready; slave is the ALU side.
interface pipelined_alu_stream_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [7:0]   fncode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         parity;
  logic         err;

  modport master (
    output in_valid, a, b, fncode, out_ready,
    input  in_ready, out_valid, result, carry, zero, parity, err
  );

  modport slave (
    input  in_valid, a, b, fncode, out_ready,
    output in_ready, out_valid, result, carry, zero, parity, err
  );
endinterface

// File: rtl/pipelined_alu_stream.sv
// Two-stage valid/ready ALU: stage 1 latches operands and the decoded one-hot op,
// stage 2 latches the result with carry/zero/parity/err flags.
module pipelined_alu_stream #(
  parameter int W          = 4,
  parameter int ODD_PARITY = 0
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_alu_stream_if.slave bus
);

  localparam logic PAR_INV = (ODD_PARITY != 0);

  logic         s1_valid;
  logic         s2_valid;
  logic         s1_en;
  logic         s2_en;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [2:0]   s1_op;
  logic         s1_ill;
  logic [2:0]   dec_op;
  logic         dec_ill;
  logic [W-1:0] s2_result;
  logic         s2_carry;
  logic         s2_zero;
  logic         s2_parity;
  logic         s2_err;
  logic [W-1:0] alu_res;
  logic         alu_cy;
  logic [W:0]   sum;
  logic [W:0]   diff;

  // Ready chain is combinational so a full pipeline still takes a beat when the sink drains.
  assign s2_en        = !s2_valid || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  always_comb begin
    dec_ill = !$onehot(bus.fncode);
    dec_op  = '0;
    for (int k = 0; k < 8; k++) begin
      if (bus.fncode[k]) dec_op = 3'(k);
    end
    if (dec_ill) dec_op = '0;
  end

  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};

  // The top bit of the extended difference is the borrow, i.e. a < b.
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    if (!s1_ill) begin
      case (s1_op)
        3'd0: {alu_cy, alu_res} = sum;
        3'd1: begin
          alu_res = diff[W-1:0];
          alu_cy  = diff[W];
        end
        3'd2: alu_res = s1_a ^ s1_b;
        3'd3: alu_res = s1_a | s1_b;
        3'd4: alu_res = s1_a & s1_b;
        3'd5: alu_res = ~(s1_a | s1_b);
        3'd6: alu_res = ~(s1_a & s1_b);
        3'd7: alu_res = ~(s1_a ^ s1_b);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_ill   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a   <= bus.a;
        s1_b   <= bus.b;
        s1_op  <= dec_op;
        s1_ill <= dec_ill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_zero   <= 1'b0;
      s2_parity <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= alu_res;
        s2_carry  <= alu_cy;
        s2_zero   <= (alu_res == '0);
        s2_parity <= (^alu_res) ^ PAR_INV;
        s2_err    <= s1_ill;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.carry     = s2_carry;
  assign bus.zero      = s2_zero;
  assign bus.parity    = s2_parity;
  assign bus.err       = s2_err;

endmodule

// File: tb/tb_pipelined_alu_stream.sv
// Scoreboard bench for pipelined_alu_stream: directed beats push expected responses,
// a negedge monitor pops and compares every output handshake.
module tb_pipelined_alu_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_alu_stream_if #(.W(4)) bus4 ();
  pipelined_alu_stream_if #(.W(8)) bus8 ();

  pipelined_alu_stream #(.W(4), .ODD_PARITY(0)) dut (.clk(clk), .rst(rst), .bus(bus4));
  pipelined_alu_stream #(.W(8), .ODD_PARITY(1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       p;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic exp_t mk(input logic [3:0] r, input logic c, z, p, e);
    exp_t x;
    x.r = r; x.c = c; x.z = z; x.p = p; x.e = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle_inputs();
    bus4.in_valid = 1'b0;
    bus4.a        = 4'($urandom);
    bus4.b        = 4'($urandom);
    bus4.fncode   = 8'($urandom);
  endtask

  task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] fn, input exp_t e);
    int n = 0;
    bus4.in_valid = 1'b1;
    bus4.a        = ta;
    bus4.b        = tb;
    bus4.fncode   = fn;
    @(negedge clk);
    while (!bus4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus4.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stuck at 0 for a=%0d b=%0d fn=%0h", ta, tb, fn);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  initial begin
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk);
      if (bus4.out_valid && bus4.out_ready) begin
        got = {bus4.result, bus4.carry, bus4.zero, bus4.parity, bus4.err};
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got r=%b c=%b z=%b p=%b e=%b expected no beat",
                   got.r, got.c, got.z, got.p, got.e);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL beat: got r=%b c=%b z=%b p=%b e=%b expected r=%b c=%b z=%b p=%b e=%b",
                     got.r, got.c, got.z, got.p, got.e, want.r, want.c, want.z, want.p, want.e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    idle_inputs();
    bus4.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.fncode    = '0;
    bus8.out_ready = 1'b1;

    #2;
    chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_result", 32'(bus4.result), 32'd0);
    chk("rst_flags", 32'({bus4.carry, bus4.zero, bus4.parity, bus4.err}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Arithmetic
    send(4'd5,  4'd6, 8'd1, mk(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'd2,  4'd3, 8'd2, mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0));
    send(4'd12, 4'd5, 8'd2, mk(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'd9,  4'd7, 8'd1, mk(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));

    // Logic ops on 1100 / 1010
    send(4'b1100, 4'b1010, 8'd4,   mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0));
    send(4'b1100, 4'b1010, 8'd8,   mk(4'b1110, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'b1100, 4'b1010, 8'd16,  mk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'b1100, 4'b1010, 8'd32,  mk(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'b1100, 4'b1010, 8'd64,  mk(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0));
    send(4'b1100, 4'b1010, 8'd128, mk(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0));

    // Illegal codes, then a legal beat
    send(4'd7, 4'd3, 8'd3, mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    send(4'd7, 4'd3, 8'd0, mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1));
    send(4'd0, 4'd0, 8'd1, mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 4 ADD beats, sink stalled for 3 cycles
    bus4.out_ready = 1'b0;
    fork
      begin
        send(4'd1,  4'd1,  8'd1, mk(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0));
        send(4'd3,  4'd4,  8'd1, mk(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0));
        send(4'd8,  4'd8,  8'd1, mk(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0));
        send(4'd15, 4'd15, 8'd1, mk(4'b1110, 1'b1, 1'b0, 1'b1, 1'b0));
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("stall_in_ready", 32'(bus4.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus4.out_valid), 32'd1);
        chk("stall_hold_result", 32'(bus4.result), 32'd2);
        @(posedge clk);
        #1;
        chk("stall_hold_result2", 32'(bus4.result), 32'd2);
        bus4.out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full
    bus4.out_ready = 1'b0;
    send(4'd1, 4'd2, 8'd1, mk(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0));
    send(4'd2, 4'd2, 8'd1, mk(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0));
    #2;
    chk("full_in_ready", 32'(bus4.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus4.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("arst_result", 32'(bus4.result), 32'd0);
    chk("arst_in_ready", 32'(bus4.in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(bus4.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(4'd4, 4'd4, 8'd1, mk(4'b1000, 1'b0, 1'b0, 1'b1, 1'b0));

    // W=8, odd parity
    bus8.in_valid = 1'b1;
    bus8.a        = 8'hFF;
    bus8.b        = 8'h01;
    bus8.fncode   = 8'd1;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.a        = 8'h5A;
    bus8.b        = 8'hC3;
    @(posedge clk);
    #1;
    chk("w8_out_valid", 32'(bus8.out_valid), 32'd1);
    chk("w8_result", 32'(bus8.result), 32'h00);
    chk("w8_flags_czpe", 32'({bus8.carry, bus8.zero, bus8.parity, bus8.err}), 32'b1110);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_stream.md
Name: pipelined_alu_stream

Overview:
- Parametrised two-stage pipelined ALU with a valid/ready stream handshake on input and output.
- Stage 1 registers the operands and decodes the 8-bit one-hot function code into a 3-bit op, flagging codes that are not one-hot.
- Stage 2 registers the ALU result with carry, zero and parity flags.
- Successor to the fixed 4-bit encoder/ALU/parity pipeline: adds width parameterisation, backpressure, reset, illegal-code detection and selectable parity sense.

Parameters:
- W, 4: operand and result width in bits, W >= 2.
- ODD_PARITY, 0: 0 gives parity = XOR of result bits; 1 gives the inverted XOR.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- fncode  in  8  one-hot function select.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- result  out  W  ALU result.
- carry  out  1  carry-out for ADD, borrow for SUB, 0 for all other ops.
- zero  out  1  high when result == 0.
- parity  out  1  parity of result, sense set by ODD_PARITY.
- err  out  1  the beat carried a non-one-hot fncode.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset: clears s1_valid and s2_valid immediately. All outputs go to 0 (out_valid, result, carry, zero, parity, err). in_ready follows its equation and is therefore 1 during reset.
- Decode (combinational, before stage 1):
  - fncode bit k (k = 0..7) set alone selects op k.
  - Ops: 0 ADD, 1 SUB (A-B), 2 XOR, 3 OR, 4 AND, 5 NOR, 6 NAND, 7 XNOR.
  - Any fncode with zero bits or more than one bit set is illegal: op forced to 0 and an illegal bit is carried with the beat.
- Handshake:
  - s2_en = !s2_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en. The ready path is combinational and has no bubble.
- Stage 1:
  - On clk with s1_en: s1_valid <= in_valid.
  - When in_valid is also high, load a, b, op and illegal.
- Stage 2:
  - On clk with s2_en: s2_valid <= s1_valid.
  - When s1_valid is also high, load result, carry, zero, parity and err, all computed from the stage-1 registers.
- Outputs: out_valid = s2_valid; result and flags are driven directly from the stage-2 registers.
- Latency: a beat accepted at edge N is presented from edge N+1 when there is no stall. Throughput is one beat per cycle.
- Arithmetic:
  - ADD: {carry, result} = a + b in W+1 bits.
  - SUB: result = (a - b) mod 2^W; carry = 1 iff a < b (unsigned).
  - Logic ops: bitwise over W bits; carry = 0.
- Illegal beat: result = 0, carry = 0, zero = 1, parity = ODD_PARITY, err = 1. The beat still occupies a slot and must be handshaken out.
- Stall (out_valid & !out_ready):
  - Stage-2 registers hold, so outputs are stable.
  - Stage 1 may still fill if it is empty. Once both stages are full, in_ready = 0.
  - No beat may be dropped or duplicated, and order must be preserved.
- Simultaneous output handshake and new input while full: both stages advance in the same edge and in_ready stays 1.
- in_valid while in_ready = 0: input is ignored and the source must hold it.
- Reset mid-operation: in-flight beats are discarded and nothing is emitted after reset releases until new beats are accepted.
- Operand values on cycles with no valid beat must not affect the outputs.

Test Plan:
- W=4, out_ready=1, inputs in successive cycles, outputs one cycle after each acceptance:
  - a=5, b=6, fncode=8'd1 -> result=1011, carry=0, zero=0, parity=1, err=0.
  - a=2, b=3, fncode=8'd2 -> result=1111, carry=1, parity=0.
  - a=12, b=5, fncode=8'd2 -> result=0111, carry=0, parity=1.
- W=4, all logic ops with a=1100, b=1010 (fncode 8'd4..8'd128) -> XOR 0110, OR 1110, AND 1000, NOR 0001, NAND 0111, XNOR 1001, carry=0 throughout.
- Illegal fncode 8'd3, then 8'd0 -> two beats each with err=1, result=0, zero=1, parity=0. A following legal beat has err=0.
- Backpressure: stream 4 ADD beats with out_ready=0 for 3 cycles.
  - in_ready falls after 2 beats are accepted and the outputs hold the first beat.
  - After out_ready rises, all 4 results emerge in order with no loss or duplication.
- Reset mid-stream: assert rst asynchronously between edges with both stages full -> out_valid and result drop to 0 before the next edge, and no stale beat appears after release.
- W=8, ODD_PARITY=1: a=8'hFF, b=8'h01, ADD -> result=8'h00, carry=1, zero=1, parity=1.
